hot_bit_rr_arbiter: RTL and testbench
=====================================

# hot_bit_rr_arbiter

Parametrised round-robin arbiter that issues a registered one-hot grant over `DEPTH` requesters, together with the binary index of the granted requester. It is the sequential successor to the combinational one-hot index decoder and arbitrates shared single-port resources such as the data-memory port and the register-file write port. Each grant is held until the owner releases it. Priority then rotates past the last owner.

## Interface
- `DEPTH`, 8: number of requesters; must be ≥2 and a power of two.
- `IDX_W`, `$clog2(DEPTH)`: index width; derived, never overridden.
- `TIMEOUT`, 16: watchdog limit in cycles; used only when `HOT_BIT_ARB_TIMEOUT_EN` is defined; must be ≥1.
- `clk` input 1: single clock; everything is rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req` input DEPTH: per-requester request level.
- `done` input 1: one-cycle release pulse from the current owner.
- `grant` output DEPTH: registered one-hot grant; all zeros when idle.
- `grant_idx` output IDX_W: binary index of the bit set in `grant`; 0 when idle.
- `grant_valid` output 1: high exactly when `grant` is non-zero.
- `timeout` output 1: one-cycle pulse when the watchdog forces a release; tied 0 without the macro.

## Operation
- State machine states: `IDLE` and `BUSY`.
- Pointer `ptr` (IDX_W bits) holds the highest-priority candidate.
- `IDLE`:
  - If `req` is non-zero, select the first set bit scanning upward from `ptr`, with modulo-DEPTH wrap.
  - Register that selection into `grant` and `grant_idx`, and go to `BUSY`.
  - If `req` is zero, stay in `IDLE`.
- `BUSY`: the grant is held, and `req` changes on other lines are ignored. A release happens when any of these is true:
  - `done` is asserted;
  - `req[grant_idx]` is 0;
  - the watchdog expires (only with the macro).
- On release:
  - `grant` becomes 0;
  - `ptr` becomes `grant_idx+1` mod DEPTH, so `DEPTH-1` wraps to 0;
  - the state returns to `IDLE`.
- `done` while in `IDLE` is ignored.
- `done` and a dropped request in the same cycle count as a single release.
- Reset asserted mid-grant: all state clears at once, asynchronously; there is no release side effect.
- Reset values:
  - `grant` = 0, `grant_idx` = 0, `grant_valid` = 0, `timeout` = 0;
  - `ptr` = 0, state = `IDLE`, watchdog counter = 0.
- Invariant: `grant` has at most one bit set, and that bit equals `1 << grant_idx`.

## Timing
- Request latency: `req` is sampled high at edge k; `grant` is visible after edge k.
- Release latency: the release condition is sampled at edge k; `grant` is 0 after edge k.
- There is a mandatory one-cycle idle gap between consecutive grants, so minimum grant spacing is 2 cycles.
- All outputs are registered; there is no combinational path from `req` or `done` to any output.
- `req` deasserted in the same cycle the arbiter samples it in `IDLE` is not granted.

## Configuration
- `HOT_BIT_ARB_TIMEOUT_EN` defined:
  - A counter clears on entry to `BUSY` and increments every `BUSY` cycle.
  - When the count reaches `TIMEOUT-1` without a release, the next edge forces a release.
  - That release updates `ptr` like a normal release and drives `timeout` high for one cycle, aligned with `grant` returning to 0.
- Macro undefined: no counter is built, `timeout` is constant 0, and grants are unbounded.

## Structure
- Package `hot_bit_pkg` holds:
  - the typedef `arb_state_t` (enum `IDLE`, `BUSY`);
  - the default-depth constant `HOT_BIT_DEPTH = 8`.
- Sub-module `hot_bit_prio`: combinational rotating priority picker.
  - Inputs: `req`, `ptr`.
  - Outputs: `pick_onehot`, `pick_idx`, `pick_any`.
  - Implemented as a double-width masked scan.
- The top level instantiates `hot_bit_prio` once and contains only the state machine, the registers and the optional watchdog.

## Test plan
All scenarios use DEPTH=8.
- Reset, then `req`=0 for 5 cycles -> all outputs 0.
- Assert `rst_n`=0 mid-grant -> outputs clear immediately, without waiting for `clk`.
- `req`=8'b0000_0100 -> after 1 edge, `grant`=0000_0100, `grant_idx`=2. Pulse `done` -> grant is 0 after the next edge and `ptr`=3.
- `req`=8'b1000_0001 held; each owner pulses `done` after 2 cycles -> grants alternate idx 7, 0, 7, 0, each separated by one idle cycle. This checks the 7→0 wrap.
- `req`=8'hFF with `done` pulsed every grant -> grant order is 0,1,…,7,0, and no requester is granted twice before all others.
- While idx 3 is granted, raise `req[1]` and drop `req[3]` -> grant releases after that edge; the next grant is idx 1.
- With `HOT_BIT_ARB_TIMEOUT_EN` and `TIMEOUT`=4: `req[5]` held high with no `done` -> grant is high for 4 cycles, then `timeout` pulses once, grant drops, and idx 5 is regranted after the idle gap. Without the macro, the grant stays up for 100 cycles and `timeout` stays 0.

Source files
------------

// File: rtl/hot_bit_pkg.sv
// hot_bit_pkg: shared arbiter state type and default depth.
package hot_bit_pkg;
    typedef enum logic {IDLE, BUSY} arb_state_t;
    localparam int HOT_BIT_DEPTH = 8;
endpackage

// File: rtl/hot_bit_rr_arbiter_prio.sv
// hot_bit_prio: rotating priority picker; first set req bit scanning up from ptr with wrap.
// Ports: req (requests), ptr (highest-priority index) -> pick_onehot, pick_idx, pick_any.
module hot_bit_prio
    import hot_bit_pkg::*;
#(
    parameter int DEPTH = HOT_BIT_DEPTH,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [DEPTH-1:0] pick_onehot,
    output logic [IDX_W-1:0] pick_idx,
    output logic             pick_any
);
    logic [2*DEPTH-1:0] w_dbl;
    logic [2*DEPTH-1:0] w_masked;
    // Upper copy is unmasked so bits below ptr are still found after wrap.
    assign w_dbl    = {req, req};
    assign w_masked = w_dbl & {{DEPTH{1'b1}}, ~((DEPTH'(1) << ptr) - DEPTH'(1))};
    always_comb begin
        pick_any = 1'b0;
        pick_idx = '0;
        for (int i = 2*DEPTH-1; i >= 0; i--) begin
            if (w_masked[i]) begin
                pick_any = 1'b1;
                pick_idx = i[IDX_W-1:0];
            end
        end
        pick_onehot = {{(DEPTH-1){1'b0}}, pick_any} << pick_idx;
    end
endmodule

// File: rtl/hot_bit_rr_arbiter.sv
// hot_bit_rr_arbiter: registered round-robin arbiter, grant held until owner releases.
// Ports: clk, rst_n (async active-low), req[DEPTH], done -> grant[DEPTH], grant_idx, grant_valid, timeout.
// Optional watchdog: define HOT_BIT_ARB_TIMEOUT_EN to force release after TIMEOUT busy cycles.
module hot_bit_rr_arbiter
    import hot_bit_pkg::*;
#(
    parameter int DEPTH   = HOT_BIT_DEPTH,
    parameter int IDX_W   = $clog2(DEPTH),
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DEPTH-1:0] req,
    input  logic             done,
    output logic [DEPTH-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid,
    output logic             timeout
);
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
        $error("hot_bit_rr_arbiter: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
    end

    arb_state_t       r_state;
    arb_state_t       w_next_state;
    logic [DEPTH-1:0] r_grant;
    logic [IDX_W-1:0] r_grant_idx;
    logic [IDX_W-1:0] r_ptr;
    logic [DEPTH-1:0] w_pick_onehot;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_pick_any;
    logic             w_wd_expire;
    logic             w_release;

    hot_bit_prio #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_prio (
        .req        (req),
        .ptr        (r_ptr),
        .pick_onehot(w_pick_onehot),
        .pick_idx   (w_pick_idx),
        .pick_any   (w_pick_any)
    );

`ifdef HOT_BIT_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;
    assign w_wd_expire = (r_state == BUSY) && (r_cnt == CNT_W'(TIMEOUT - 1));
    // Counter sits at 0 in IDLE, so the first BUSY cycle always sees 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_cnt     <= (r_state == IDLE) ? '0 : r_cnt + CNT_W'(1);
            r_timeout <= w_wd_expire;
        end
    end
    assign timeout = r_timeout;
`else
    assign w_wd_expire = 1'b0;
    assign timeout     = 1'b0;
`endif

    assign w_release = (r_state == BUSY) && (done || !req[r_grant_idx] || w_wd_expire);

    always_comb begin
        w_next_state = r_state;
        if (r_state == IDLE)
            w_next_state = w_pick_any ? BUSY : IDLE;
        else
            w_next_state = w_release ? IDLE : BUSY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_grant_idx <= '0;
            r_ptr       <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == IDLE && w_pick_any) begin
                r_grant     <= w_pick_onehot;
                r_grant_idx <= w_pick_idx;
            end else if (w_release) begin
                r_grant     <= '0;
                r_grant_idx <= '0;
                r_ptr       <= r_grant_idx + IDX_W'(1);
            end
        end
    end

    assign grant       = r_grant;
    assign grant_idx   = r_grant_idx;
    assign grant_valid = |r_grant;
endmodule

// File: tb/tb_hot_bit_rr_arbiter.sv
// tb_hot_bit_rr_arbiter: directed self-checking bench for hot_bit_rr_arbiter at DEPTH=8.
module tb_hot_bit_rr_arbiter;
`ifdef HOT_BIT_ARB_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 16;
`endif
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = '0;
    logic       done = 1'b0;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       timeout;
    int checks = 0;
    int failures = 0;

    hot_bit_rr_arbiter #(.DEPTH(8), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .done       (done),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // i < 0 means idle (no grant expected).
    task automatic chk_out(input string tag, input int i, input logic t = 1'b0);
        logic [7:0] g;
        logic [2:0] x;
        g = (i < 0) ? 8'h00 : 8'(1 << i);
        x = (i < 0) ? 3'd0 : 3'(i);
        chk({tag, ".grant"}, 32'(grant), 32'(g));
        chk({tag, ".idx"}, 32'(grant_idx), 32'(x));
        chk({tag, ".valid"}, 32'(grant_valid), 32'(i >= 0));
        chk({tag, ".timeout"}, 32'(timeout), 32'(t));
    endtask

    // Entered just after the granting edge; owner holds 2 cycles, pulses done,
    // then one idle cycle; returns just after the following grant edge.
    task automatic grant_cycle(input string tag, input int i);
        chk_out({tag, ".c1"}, i);
        @(negedge clk);
        chk_out({tag, ".c2"}, i);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        chk_out({tag, ".gap"}, -1);
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        chk_out("reset", -1);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk_out("idle_noreq", -1);
        end

        req = 8'b0000_0100;
        @(negedge clk);
        chk_out("single2", 2);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        chk_out("single2_rel", -1);
        req = 8'b0000_1100;
        @(negedge clk);
        chk_out("ptr3", 3);
        req = 8'h00;
        @(negedge clk);
        chk_out("drop3_rel", -1);

        req = 8'h01;
        @(negedge clk);
        chk_out("wrap_to0", 0);
        #3 rst_n = 1'b0;
        #1 chk_out("async_rst", -1);
        @(negedge clk);
        req = 8'h00;
        rst_n = 1'b1;
        @(negedge clk);
        chk_out("post_rst", -1);

        req = 8'h40;
        @(negedge clk);
        chk_out("grant6", 6);
        req = 8'h00;
        @(negedge clk);
        chk_out("grant6_rel", -1);

        req = 8'b1000_0001;
        @(negedge clk);
        grant_cycle("alt_a7", 7);
        grant_cycle("alt_b0", 0);
        grant_cycle("alt_c7", 7);
        grant_cycle("alt_d0", 0);
        chk_out("alt_e7", 7);
        req = 8'h00;
        @(negedge clk);
        chk_out("alt_rel", -1);

        req = 8'hFF;
        @(negedge clk);
        for (int i = 0; i < 8; i++) grant_cycle($sformatf("ff%0d", i), i);
        chk_out("ff_wrap0", 0);
        req = 8'h00;
        @(negedge clk);
        chk_out("ff_rel", -1);

        req = 8'h08;
        @(negedge clk);
        chk_out("own3", 3);
        req = 8'h02;
        @(negedge clk);
        chk_out("own3_rel", -1);
        @(negedge clk);
        chk_out("next1", 1);
        req = 8'h00;
        done = 1'b1;
        @(negedge clk);
        chk_out("dual_rel", -1);

        req = 8'hFF;
        @(negedge clk);
        chk_out("done_idle_ign", 2);
        done = 1'b0;
        req = 8'hFB | 8'h04;
        @(negedge clk);
        chk_out("hold2", 2);
        req = 8'h00;
        @(negedge clk);
        chk_out("hold2_rel", -1);

        req = 8'h20;
        @(negedge clk);
`ifdef HOT_BIT_ARB_TIMEOUT_EN
        for (int k = 0; k < 4; k++) begin
            chk_out($sformatf("wd_busy%0d", k), 5);
            @(negedge clk);
        end
        chk_out("wd_fire", -1, 1'b1);
        @(negedge clk);
        chk_out("wd_regrant", 5);
`else
        for (int k = 0; k < 100; k++) begin
            chk_out("long_hold", 5);
            @(negedge clk);
        end
        chk_out("long_hold_end", 5);
`endif
        req = 8'h00;
        @(negedge clk);
        chk_out("final_rel", -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
